conv3x3_kernel_filter: RTL and testbench
========================================

Name: conv3x3_kernel_filter

Overview:
- Parametrised 3x3 convolution engine for the video path, placed after the line-buffer window generator and before the VGA/RGB output mux.
- Accepts one 9-pixel window per beat and produces one filtered pixel per beat.
- Runtime-selectable kernel: Sobel X, Sobel Y, Gaussian blur, or gradient magnitude.
- Generalises the fixed Sobel filter in channel width, channel count, gain and sign handling. Adds valid/ready back-pressure, a frame-aligned mode latch and a latency-aligned original-pixel output.

Parameters:
- CW, 4, bits per colour channel.
- NCH, 3, number of colour channels; pixel width PW = NCH*CW, with channel NCH-1 in the MSBs.
- GAIN_SHL, 0, left shift applied to gradient results before saturation (0..4).
- ABS_GRAD, 0, 0 = negative gradients clamp to 0; 1 = absolute value taken.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_window  in  9*PW  packed window, MSB to LSB: centre, left, right, up, down, upleft, upright, downleft, downright.
- in_valid  in  1  window valid.
- in_sof  in  1  first window of a frame; qualified by in_valid.
- in_ready  out  1  block accepts the window this cycle.
- mode_sel  in  2  kernel select; sampled only on an accepted beat with in_sof=1.
- out_pixel  out  PW  filtered pixel.
- out_orig  out  PW  centre pixel of the same window, aligned with out_pixel.
- out_valid  out  1  output valid.
- out_sof  out  1  in_sof delayed with the data.
- out_ready  in  1  downstream accepts.

Behaviour:
- Clocking and reset: single clock domain; all state updates on posedge clk.
- When reset=1 at a clock edge:
  - out_valid, out_sof, all stage valids = 0.
  - out_pixel, out_orig = 0.
  - Mode register = 0.
  - Reset mid-stream discards all in-flight beats; no partial outputs appear afterwards.
- Handshake:
  - adv = out_ready | ~out_valid.
  - in_ready = adv, combinational.
  - A beat is accepted when in_valid & in_ready.
  - When adv=0, every stage holds its data and valid; no beat is lost or duplicated.
  - out_pixel, out_orig and out_sof stay stable while out_valid=1 and out_ready=0.
- Pipeline: 3 register stages; latency 3 cycles from accept to out_valid when unstalled; throughput 1 beat/cycle.
  - S1: register the window, in_sof and the effective mode. Effective mode = mode_sel if in_sof, else the mode register. The mode register is updated on the same edge.
  - S2: per-channel signed weighted sums, held at width CW+5 (signed).
  - S3: post-processing and saturation to CW bits; centre pixel carried through all stages for out_orig.
- Kernels (rows top, mid, bottom):
  - Mode 0, Sobel X: [-1 0 1; -2 0 2; -1 0 1].
  - Mode 1, Sobel Y: [-1 -2 -1; 0 0 0; 1 2 1].
  - Mode 2, Gaussian: [1 2 1; 2 4 2; 1 2 1], result = sum >> 4 (truncating). No gain is applied; the result never saturates.
  - Mode 3: see Optional Feature.
- Gradient post-processing (modes 0, 1, 3):
  - Apply ABS or clamp per ABS_GRAD.
  - Then shift left by GAIN_SHL.
  - Then saturate: any value > 2^CW-1 outputs 2^CW-1.
- Channels are processed independently and identically.
- Mode changes without in_sof are ignored. A new mode takes effect exactly at the window carrying in_sof.
- in_sof=1 with in_valid=0 has no effect.

Optional Feature:
- Macro: CONV3X3_MAG_EN.
- Defined: mode 3 = |Gx| + |Gy| per channel, computed in S2/S3 with width CW+6. GAIN_SHL is applied, then saturation. ABS_GRAD is irrelevant for mode 3.
- Not defined: mode 3 outputs out_pixel = centre pixel (passthrough) with the same 3-cycle latency. No magnitude logic is synthesised.

Test Plan (CW=4, NCH=3, GAIN_SHL=0, ABS_GRAD=0 unless stated):
- Reset test: hold reset 2 cycles during an active stream -> out_valid=0, out_pixel=0x000 and out_orig=0x000 on the next cycle. The first post-reset output uses mode 0.
- Small gradient: sof beat with mode_sel=0; left column 0x111, right column 0x222, centre 0x5A5 -> out_pixel=0x444, out_orig=0x5A5 exactly 3 cycles after accept.
- Sobel Y saturation: mode 1; top row 0x000, bottom row 0xFFF -> 0xFFF.
- Sobel Y inverted (top row 0xFFF, bottom row 0x000):
  - ABS_GRAD=0 -> 0x000.
  - ABS_GRAD=1 -> 0xFFF.
- Gaussian and mode latch: mode 2 on a uniform 0x7A3 window -> 0x7A3. Change mode_sel to 0 on a non-sof beat -> outputs stay 0x7A3. Next beat with in_sof=1 and mode_sel=0 -> 0x000.
- Back-pressure: stream 6 distinct windows with out_ready low for 5 cycles mid-burst -> in_ready low during the stall, all 6 outputs delivered in order with no drops or duplicates, outputs stable while stalled.
- Mode 3, single case: mode 3; left column 0x000, right column 0x111, all other pixels 0x000:
  - CONV3X3_MAG_EN defined -> 0x444.
  - CONV3X3_MAG_EN undefined -> out_pixel = centre = 0x000.

Source files
------------

// File: rtl/conv3x3_kernel_filter.sv
// 3x3 convolution engine with Sobel X/Y, Gaussian and gradient magnitude kernels, valid/ready stall.
// Optional macro CONV3X3_MAG_EN enables the |Gx|+|Gy| magnitude kernel on mode 3 (else centre passthrough).
module conv3x3_kernel_filter #(
    parameter int CW       = 4,
    parameter int NCH      = 3,
    parameter int GAIN_SHL = 0,
    parameter int ABS_GRAD = 0,
    localparam int PW      = NCH * CW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [9*PW-1:0] in_window,
    input  logic            in_valid,
    input  logic            in_sof,
    output logic            in_ready,
    input  logic [1:0]      mode_sel,
    output logic [PW-1:0]   out_pixel,
    output logic [PW-1:0]   out_orig,
    output logic            out_valid,
    output logic            out_sof,
    input  logic            out_ready
);
    localparam int SW = CW + 5;
    localparam int MW = CW + 6;
    localparam int XW = MW + 4;
    localparam logic [XW-1:0] PMAX = XW'((1 << CW) - 1);
    localparam logic USE_ABS = (ABS_GRAD != 0);

    logic                      adv;
    logic [3:1]                vld_pipe;
    logic [1:0]                mode_reg, eff_mode;
    logic [9*PW-1:0]           s1_win;
    logic                      s1_sof;
    logic [1:0]                s1_mode;
    logic [NCH-1:0][SW-1:0]    s2_sum_d, s2_sum;
    logic [PW-1:0]             s2_centre;
    logic                      s2_sof;
    logic [1:0]                s2_mode;
    logic [NCH-1:0][CW-1:0]    pix_d;
`ifdef CONV3X3_MAG_EN
    logic [NCH-1:0][SW-1:0]    s2_gy_d, s2_gy;
`endif

    assign adv       = out_ready | ~vld_pipe[3];
    assign in_ready  = adv;
    assign out_valid = vld_pipe[3];
    assign eff_mode  = in_sof ? mode_sel : mode_reg;

    // Signed sum -> non-negative magnitude; negatives either clamp or fold.
    function automatic logic [MW-1:0] mag_of(input logic [SW-1:0] v, input logic take_abs);
        logic [SW-1:0] neg;
        neg = -v;
        if (!v[SW-1]) return {1'b0, v};
        return take_abs ? {1'b0, neg} : '0;
    endfunction

    function automatic logic [XW-1:0] shl(input logic [MW-1:0] v);
        return {4'b0, v} << GAIN_SHL;
    endfunction

    function automatic logic [CW-1:0] sat(input logic [XW-1:0] v);
        return (v > PMAX) ? '1 : v[CW-1:0];
    endfunction

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic signed [SW-1:0] p [9];
        logic signed [SW-1:0] gx, gy, gs;
        logic [SW-1:0]        s;
        logic [CW-1:0]        gauss_v, grad_v, alt_v;

        // p[8]=centre, 7=left, 6=right, 5=up, 4=down, 3=ul, 2=ur, 1=dl, 0=dr
        for (genvar k = 0; k < 9; k++) begin : g_tap
            assign p[k] = $signed(SW'(s1_win[k*PW + c*CW +: CW]));
        end

        assign gx = (p[2] + (p[6] <<< 1) + p[0]) - (p[3] + (p[7] <<< 1) + p[1]);
        assign gy = (p[1] + (p[4] <<< 1) + p[0]) - (p[3] + (p[5] <<< 1) + p[2]);
        assign gs = p[3] + p[2] + p[1] + p[0] + ((p[5] + p[4] + p[7] + p[6]) <<< 1) + (p[8] <<< 2);
        assign s2_sum_d[c] = (s1_mode == 2'd1) ? gy : (s1_mode == 2'd2) ? gs : gx;

        assign s       = s2_sum[c];
        assign gauss_v = s[CW+3:4];
        assign grad_v  = sat(shl(mag_of(s, USE_ABS)));
`ifdef CONV3X3_MAG_EN
        logic [MW-1:0] mag;
        assign s2_gy_d[c] = gy;
        assign mag        = mag_of(s, 1'b1) + mag_of(s2_gy[c], 1'b1);
        assign alt_v      = sat(shl(mag));
`else
        assign alt_v      = s2_centre[c*CW +: CW];
`endif
        assign pix_d[c] = (s2_mode == 2'd2) ? gauss_v : (s2_mode == 2'd3) ? alt_v : grad_v;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe  <= '0;
            mode_reg  <= '0;
            s1_win    <= '0;
            s1_sof    <= 1'b0;
            s1_mode   <= '0;
            s2_sum    <= '0;
            s2_centre <= '0;
            s2_sof    <= 1'b0;
            s2_mode   <= '0;
            out_pixel <= '0;
            out_orig  <= '0;
            out_sof   <= 1'b0;
`ifdef CONV3X3_MAG_EN
            s2_gy     <= '0;
`endif
        end else begin
            if (in_valid && adv && in_sof) mode_reg <= mode_sel;
            // Global stall: every stage moves together, so nothing is lost or duplicated.
            if (adv) begin
                vld_pipe  <= {vld_pipe[2:1], in_valid};
                s1_win    <= in_window;
                s1_sof    <= in_valid & in_sof;
                s1_mode   <= eff_mode;
                s2_sum    <= s2_sum_d;
                s2_centre <= s1_win[8*PW +: PW];
                s2_sof    <= s1_sof;
                s2_mode   <= s1_mode;
                out_pixel <= pix_d;
                out_orig  <= s2_centre;
                out_sof   <= s2_sof;
`ifdef CONV3X3_MAG_EN
                s2_gy     <= s2_gy_d;
`endif
            end
        end
    end
endmodule

// File: tb/tb_conv3x3_kernel_filter.sv
// Scoreboard bench: default instance plus an ABS_GRAD=1 / GAIN_SHL=1 instance on shared inputs.
module tb_conv3x3_kernel_filter;
    logic         clk = 1'b0;
    logic         reset, in_valid, in_sof, out_ready;
    logic [1:0]   mode_sel;
    logic [107:0] in_window;
    logic         in_ready0, out_valid0, out_sof0;
    logic [11:0]  out_pixel0, out_orig0;
    logic         in_ready1, out_valid1, out_sof1;
    logic [11:0]  out_pixel1, out_orig1;

    typedef struct { logic [11:0] pix; logic [11:0] orig; logic sof; } exp_t;
    exp_t q0[$], q1[$];

    int n_cmp = 0, n_bad = 0, cyc = 0, acc_cyc = 0;
    logic [1:0] tb_mode = 2'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    conv3x3_kernel_filter dut0 (
        .clk(clk), .reset(reset), .in_window(in_window), .in_valid(in_valid), .in_sof(in_sof),
        .in_ready(in_ready0), .mode_sel(mode_sel), .out_pixel(out_pixel0), .out_orig(out_orig0),
        .out_valid(out_valid0), .out_sof(out_sof0), .out_ready(out_ready));

    conv3x3_kernel_filter #(.GAIN_SHL(1), .ABS_GRAD(1)) dut1 (
        .clk(clk), .reset(reset), .in_window(in_window), .in_valid(in_valid), .in_sof(in_sof),
        .in_ready(in_ready1), .mode_sel(mode_sel), .out_pixel(out_pixel1), .out_orig(out_orig1),
        .out_valid(out_valid1), .out_sof(out_sof1), .out_ready(out_ready));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [107:0] mkwin(input logic [11:0] c, l, r, u, d, ul, ur, dl, dr);
        return {c, l, r, u, d, ul, ur, dl, dr};
    endfunction

    function automatic logic [11:0] model(input logic [107:0] w, input logic [1:0] m, input int ab, input int gn);
        logic [11:0] res;
        res = '0;
        for (int c = 0; c < 3; c++) begin
            int p[9];
            int gx, gy, g;
            for (int k = 0; k < 9; k++) p[k] = int'(w[k*12 + c*4 +: 4]);
            gx = p[2] + 2*p[6] + p[0] - p[3] - 2*p[7] - p[1];
            gy = p[1] + 2*p[4] + p[0] - p[3] - 2*p[5] - p[2];
            case (m)
                2'd2: g = (p[3] + 2*p[5] + p[2] + 2*p[7] + 4*p[8] + 2*p[6] + p[1] + 2*p[4] + p[0]) / 16;
                2'd3: begin
`ifdef CONV3X3_MAG_EN
                    g = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) << gn;
                    if (g > 15) g = 15;
`else
                    g = p[8];
`endif
                end
                default: begin
                    g = (m == 2'd1) ? gy : gx;
                    if (g < 0) g = (ab != 0) ? -g : 0;
                    g = g << gn;
                    if (g > 15) g = 15;
                end
            endcase
            res[c*4 +: 4] = 4'(g);
        end
        return res;
    endfunction

    task automatic send(input logic [107:0] w, input logic sof, input logic [1:0] m);
        exp_t e;
        in_window = w; in_sof = sof; mode_sel = m; in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            chk("in_ready_match", in_ready1, in_ready0);
            if (in_ready0) begin
                if (sof) tb_mode = m;
                e.orig = w[107:96]; e.sof = sof;
                e.pix = model(w, tb_mode, 0, 0); q0.push_back(e);
                e.pix = model(w, tb_mode, 1, 1); q1.push_back(e);
                acc_cyc = cyc;
                @(posedge clk); #1;
                in_valid = 1'b0; in_sof = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        chk("send_timeout", 1, 0);
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0) break;
        end
        chk("drain", q0.size() + q1.size(), 0);
        @(posedge clk); #1;
    endtask

    // Output monitor: pops on transfer, checks hold stability during stalls.
    logic        stalled = 1'b0;
    logic [11:0] h_pix, h_orig;
    always @(negedge clk) begin
        exp_t e;
        if (reset) stalled = 1'b0;
        else begin
            if (stalled) begin
                chk("hold_valid", out_valid0, 1);
                chk("hold_pix", out_pixel0, h_pix);
                chk("hold_orig", out_orig0, h_orig);
            end
            if (out_valid0 && !out_ready) begin
                chk("in_ready_stall", in_ready0, 0);
                stalled = 1'b1; h_pix = out_pixel0; h_orig = out_orig0;
            end else stalled = 1'b0;
            if (out_valid0 && out_ready) begin
                if (q0.size() == 0) chk("unexpected_out0", 1, 0);
                else begin
                    e = q0.pop_front();
                    chk("pix0", out_pixel0, e.pix);
                    chk("orig0", out_orig0, e.orig);
                    chk("sof0", out_sof0, e.sof);
                end
            end
            if (out_valid1 && out_ready) begin
                if (q1.size() == 0) chk("unexpected_out1", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("pix1", out_pixel1, e.pix);
                    chk("orig1", out_orig1, e.orig);
                    chk("sof1", out_sof1, e.sof);
                end
            end
        end
    end

    initial begin
        logic [107:0] w;
        logic done;
        reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; mode_sel = 2'd0; in_window = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", out_valid0, 0);
        chk("rst_pix", out_pixel0, 12'h000);
        chk("rst_orig", out_orig0, 12'h000);
        chk("rst_ready", in_ready0, 1);
        @(posedge clk); #1;

        // Small gradient with exact latency.
        send(mkwin(12'h5A5, 12'h111, 12'h222, 12'h000, 12'h000, 12'h111, 12'h222, 12'h111, 12'h222), 1'b1, 2'd0);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid0) break;
        end
        chk("lat_valid", out_valid0, 1);
        chk("latency", cyc - acc_cyc, 3);
        chk("small_grad_pix", out_pixel0, 12'h444);
        chk("small_grad_orig", out_orig0, 12'h5A5);
        drain();

        // Sobel Y saturation and inverted gradient.
        send(mkwin(12'h000, 12'h000, 12'h000, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'hFFF, 12'hFFF), 1'b1, 2'd1);
        send(mkwin(12'h000, 12'h000, 12'h000, 12'hFFF, 12'h000, 12'hFFF, 12'hFFF, 12'h000, 12'h000), 1'b0, 2'd3);
        drain();

        // Gaussian plus mode latch: non-sof mode change ignored, sof change applied.
        w = {9{12'h7A3}};
        send(w, 1'b1, 2'd2);
        send(w, 1'b0, 2'd0);
        send(w, 1'b1, 2'd0);
        drain();

        // Back-pressure: 6 distinct windows, out_ready low for 5 cycles mid-burst.
        fork
            begin
                send(mkwin(12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF, 12'h012, 12'h345, 12'h678, 12'h9AB), 1'b1, 2'd1);
                for (int i = 1; i < 6; i++)
                    send({$urandom, $urandom, $urandom, $urandom} , 1'b0, 2'd0);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Mode 3 single case.
        send(mkwin(12'h000, 12'h000, 12'h111, 12'h000, 12'h000, 12'h000, 12'h111, 12'h000, 12'h111), 1'b1, 2'd3);
        drain();

        // Random stream with random back-pressure and idle gaps.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    send({$urandom, $urandom, $urandom, $urandom}, ($urandom_range(0, 3) == 0), 2'($urandom));
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        drain();

        // Reset mid-stream discards in-flight beats and the mode register.
        send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 2'd1);
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 2'd1);
        reset = 1'b1;
        q0.delete(); q1.delete(); tb_mode = 2'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", out_valid0, 0);
        chk("mid_rst_pix", out_pixel0, 12'h000);
        chk("mid_rst_orig", out_orig0, 12'h000);
        @(posedge clk); #1;
        send(mkwin(12'h5A5, 12'h111, 12'h222, 12'h000, 12'h000, 12'h111, 12'h222, 12'h111, 12'h222), 1'b0, 2'd2);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
